// File: rtl/seg7_multi_disp.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_multi_disp
//  Purpose  : N-digit hex driver for active-low seven-segment displays.
//             Captures a NUM_DIGITS x 4-bit value and its decimal points
//             through a load/ack strobe. Also provides leading-zero blanking,
//             per-digit blink and PWM brightness, and registers every output.
//  Ports    :
//    iCLK     in   1             system clock
//    iRST_N   in   1             synchronous active-low reset
//    iVALUE   in   4*NUM_DIGITS  hex value, digit i = iVALUE[4i+3:4i]
//    iDP      in   NUM_DIGITS    decimal point request per digit (1 = lit)
//    iLOAD    in   1             capture strobe for iVALUE / iDP
//    oACK     out  1             one-cycle pulse per captured load
//    iLZ_EN   in   1             leading-zero blanking enable (live)
//    iBLINK   in   NUM_DIGITS    per-digit blink mask (live)
//    iBRIGHT  in   PWM_BITS      brightness, 0 = off, all-ones = full on
//    oHEX     out  8*NUM_DIGITS  segments, digit i = oHEX[8i+7:8i],
//                                bit order hgfedcba (h = DP), active-low
//  Revision : 1.0  initial release
// ============================================================================
module seg7_multi_disp #(
   parameter int NUM_DIGITS = 8,
   parameter int BLINK_HALF = 25000000,
   parameter int PWM_BITS   = 4
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   input  logic [4*NUM_DIGITS-1:0] iVALUE,
   input  logic [NUM_DIGITS-1:0]   iDP,
   input  logic                    iLOAD,
   output logic                    oACK,
   input  logic                    iLZ_EN,
   input  logic [NUM_DIGITS-1:0]   iBLINK,
   input  logic [PWM_BITS-1:0]     iBRIGHT,
   output logic [8*NUM_DIGITS-1:0] oHEX
);

   // Blink counter width; BLINK_HALF >= 2 keeps this at least one bit.
   localparam int                 c_BLINK_W    = $clog2(BLINK_HALF);
   localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [4*NUM_DIGITS-1:0] r_value;
   logic [NUM_DIGITS-1:0]   r_dp;
   logic                    r_ack;
   logic [c_BLINK_W-1:0]    r_blink_cnt;
   logic                    r_blink_phase;
   logic [PWM_BITS-1:0]     r_pwm_cnt;
   logic [8*NUM_DIGITS-1:0] r_hex;

   // ------------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------------
   logic [NUM_DIGITS-1:0]   w_zero_from;  // digit i and all above are zero
   logic [NUM_DIGITS-1:0]   w_blank;      // segments blanked by LZ rule
   logic [NUM_DIGITS-1:0]   w_dark;       // whole digit (incl. DP) dark
   logic [8*NUM_DIGITS-1:0] w_hex_next;
   logic                    w_pwm_lit;

   // Active-high segment code, bit order gfedcba.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   // All-ones brightness is forced on; otherwise the comparison alone would
   // leave the display dark for the one counter value equal to iBRIGHT.
   assign w_pwm_lit = (&iBRIGHT) || (r_pwm_cnt < iBRIGHT);

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [3:0] w_nib;
      logic [6:0] w_seg;
      logic [7:0] w_code;

      assign w_nib = r_value[4*i +: 4];

      // Zero chain runs from the most significant digit downwards.
      if (i == NUM_DIGITS - 1) begin : g_top
         assign w_zero_from[i] = (w_nib == 4'h0);
      end else begin : g_chain
         assign w_zero_from[i] = (w_nib == 4'h0) && w_zero_from[i+1];
      end

      // Digit 0 always shows something so a zero value reads as "0".
      if (i == 0) begin : g_lsd
         assign w_blank[i] = 1'b0;
      end else begin : g_upper
         assign w_blank[i] = iLZ_EN && w_zero_from[i];
      end

      assign w_dark[i] = (r_blink_phase && iBLINK[i]) || !w_pwm_lit;

      // LZ blanking clears the segments only; the DP keeps following r_dp.
      assign w_seg  = w_blank[i] ? 7'h00 : seg_decode(w_nib);
      assign w_code = w_dark[i] ? 8'h00 : {r_dp[i], w_seg};

      assign w_hex_next[8*i +: 8] = ~w_code;
   end

   // ------------------------------------------------------------------------
   // Sequential
   // ------------------------------------------------------------------------
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_value       <= '0;
         r_dp          <= '0;
         r_ack         <= 1'b0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_pwm_cnt     <= '0;
         r_hex         <= '1;
      end else begin
         // Capture handshake: no back-pressure, a load is always taken.
         if (iLOAD) begin
            r_value <= iVALUE;
            r_dp    <= iDP;
         end
         r_ack <= iLOAD;

         // Blink timebase is free-running; loads never disturb it.
         if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end

         r_pwm_cnt <= r_pwm_cnt + 1'b1;

         r_hex <= w_hex_next;
      end
   end

   assign oACK = r_ack;
   assign oHEX = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_seg7_multi_disp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_multi_disp
//  Purpose  : Self-checking bench for seg7_multi_disp (4 digits, blink
//             half-period 8, 2-bit PWM). Decode/LZ cases are table driven;
//             reset, blink, PWM and back-to-back loads are hand sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_multi_disp;

   localparam int NUM_DIGITS = 4;
   localparam int BLINK_HALF = 8;
   localparam int PWM_BITS   = 2;

   logic        clk;
   logic        iRST_N;
   logic [15:0] iVALUE;
   logic [3:0]  iDP;
   logic        iLOAD;
   logic        oACK;
   logic        iLZ_EN;
   logic [3:0]  iBLINK;
   logic [1:0]  iBRIGHT;
   logic [31:0] oHEX;

   int errors = 0;
   int checks = 0;
   int n;          // edges since reset release (0 = first released edge)

   seg7_multi_disp #(
      .NUM_DIGITS (NUM_DIGITS),
      .BLINK_HALF (BLINK_HALF),
      .PWM_BITS   (PWM_BITS)
   ) u_dut (
      .iCLK    (clk),
      .iRST_N  (iRST_N),
      .iVALUE  (iVALUE),
      .iDP     (iDP),
      .iLOAD   (iLOAD),
      .oACK    (oACK),
      .iLZ_EN  (iLZ_EN),
      .iBLINK  (iBLINK),
      .iBRIGHT (iBRIGHT),
      .oHEX    (oHEX)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic        lz;
      logic [31:0] exp_hex;
   } vec_t;

   vec_t vecs [12];

   task automatic tick;
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (n=%0d): got %h, expected %h", name, n, act, exp);
      end
   endtask

   // Expected display for value 1111 with digit 0 blinking, edge n after release.
   function automatic logic [31:0] blink_exp(input int edge_n);
      return ((edge_n / 8) % 2 == 1) ? 32'hF9F9F9FF : 32'hF9F9F9F9;
   endfunction

   initial begin
      vecs[0]  = '{16'hA5F0, 4'b0100, 1'b0, 32'h88128EC0};
      vecs[1]  = '{16'h0070, 4'b0000, 1'b1, 32'hFFFFF8C0};
      vecs[2]  = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
      vecs[3]  = '{16'h0000, 4'b0000, 1'b0, 32'hC0C0C0C0};
      vecs[4]  = '{16'h89AB, 4'b0000, 1'b0, 32'h80908883};
      vecs[5]  = '{16'hCDEF, 4'b1111, 1'b0, 32'h4621060E};
      vecs[6]  = '{16'h0123, 4'b0000, 1'b0, 32'hC0F9A4B0};
      vecs[7]  = '{16'h0123, 4'b0000, 1'b1, 32'hFFF9A4B0};
      vecs[8]  = '{16'h0000, 4'b1000, 1'b1, 32'h7FFFFFC0};
      vecs[9]  = '{16'h4567, 4'b0000, 1'b0, 32'h999282F8};
      vecs[10] = '{16'h0100, 4'b0000, 1'b1, 32'hFFF9C0C0};
      vecs[11] = '{16'h1000, 4'b0000, 1'b1, 32'hF9C0C0C0};

      n       = 0;
      iRST_N  = 1'b0;
      iLOAD   = 1'b1;
      iVALUE  = 16'h1234;
      iDP     = 4'b0000;
      iLZ_EN  = 1'b0;
      iBLINK  = 4'b0000;
      iBRIGHT = 2'd3;

      // Reset holds with a load pending.
      for (int k = 0; k < 3; k++) begin
         tick;
         check("rst_hex", oHEX, 32'hFFFFFFFF);
         check("rst_ack", {31'b0, oACK}, 32'h0);
      end

      // Release with a load of 1111 and digit 0 blinking; counters from 0.
      iRST_N = 1'b1;
      iVALUE = 16'h1111;
      iBLINK = 4'b0001;
      n      = -1;
      tick;
      check("rel_ack", {31'b0, oACK}, 32'h1);
      check("rel_hex", oHEX, 32'hC0C0C0C0);
      iLOAD = 1'b0;
      for (int k = 1; k < 32; k++) begin
         if (k == 10) iLOAD = 1'b1;   // mid-period load must not shift phase
         tick;
         if (k == 10) begin
            check("blink_load_ack", {31'b0, oACK}, 32'h1);
            iLOAD = 1'b0;
         end
         check("blink", oHEX, blink_exp(n));
      end

      // PWM with brightness 1: lit one cycle in four.
      iBLINK  = 4'b0000;
      iBRIGHT = 2'd1;
      for (int k = 0; k < 8; k++) begin
         tick;
         check("pwm1", oHEX, (n % 4 == 0) ? 32'hF9F9F9F9 : 32'hFFFFFFFF);
      end
      iBRIGHT = 2'd0;
      for (int k = 0; k < 4; k++) begin
         tick;
         check("pwm0", oHEX, 32'hFFFFFFFF);
      end
      iBRIGHT = 2'd3;
      for (int k = 0; k < 4; k++) begin
         tick;
         check("pwm3", oHEX, 32'hF9F9F9F9);
      end

      // Decode and leading-zero table.
      for (int v = 0; v < 12; v++) begin
         iVALUE = vecs[v].value;
         iDP    = vecs[v].dp;
         iLZ_EN = vecs[v].lz;
         iLOAD  = 1'b1;
         tick;
         check($sformatf("vec%0d_ack_hi", v), {31'b0, oACK}, 32'h1);
         iLOAD = 1'b0;
         tick;
         check($sformatf("vec%0d_ack_lo", v), {31'b0, oACK}, 32'h0);
         check($sformatf("vec%0d_hex", v), oHEX, vecs[v].exp_hex);
      end
      iLZ_EN = 1'b0;
      iDP    = 4'b0000;

      // Back-to-back loads 1, 2, 3.
      iLOAD  = 1'b1;
      iVALUE = 16'h0001;
      tick;
      check("b2b_ack1", {31'b0, oACK}, 32'h1);
      iVALUE = 16'h0002;
      tick;
      check("b2b_ack2", {31'b0, oACK}, 32'h1);
      check("b2b_hex1", oHEX, 32'hC0C0C0F9);
      iVALUE = 16'h0003;
      tick;
      check("b2b_ack3", {31'b0, oACK}, 32'h1);
      check("b2b_hex2", oHEX, 32'hC0C0C0A4);
      iLOAD = 1'b0;
      tick;
      check("b2b_ack_end", {31'b0, oACK}, 32'h0);
      check("b2b_hex3", oHEX, 32'hC0C0C0B0);

      // Reset in the middle of blinking.
      iVALUE = 16'h1111;
      iLOAD  = 1'b1;
      tick;
      iLOAD  = 1'b0;
      iBLINK = 4'b0001;
      for (int k = 0; k < 11; k++) tick;
      iRST_N = 1'b0;
      iLOAD  = 1'b1;
      tick;
      check("mrst_hex", oHEX, 32'hFFFFFFFF);
      check("mrst_ack", {31'b0, oACK}, 32'h0);
      iRST_N = 1'b1;
      n      = -1;
      tick;
      check("mrst_rel_ack", {31'b0, oACK}, 32'h1);
      check("mrst_rel_hex", oHEX, 32'hC0C0C0C0);
      iLOAD = 1'b0;
      for (int k = 1; k < 10; k++) begin
         tick;
         check("mrst_blink", oHEX, blink_exp(n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
